// File: rtl/colour_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | colour_pkg: shared types and pixel decode helpers for the colour path   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package colour_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } mode_t;

  localparam int PEN_W = 4;

  // Pen index of the leftmost pixel still held in the shift register.
  function automatic logic [PEN_W-1:0] pen_decode(input mode_t mode, input logic [7:0] s);
    logic [PEN_W-1:0] pen;
    case (mode)
      MODE0:   pen = {s[1], s[5], s[3], s[7]};
      MODE2:   pen = {3'b000, s[7]};
      default: pen = {2'b00, s[3], s[7]};
    endcase
    return pen;
  endfunction

  function automatic logic [2:0] pix_shift_ticks(input mode_t mode);
    logic [2:0] ticks;
    case (mode)
      MODE0:   ticks = 3'd4;
      MODE2:   ticks = 3'd1;
      default: ticks = 3'd2;
    endcase
    return ticks;
  endfunction

endpackage
`default_nettype wire

// File: rtl/colour_palette_rf.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | colour_palette_rf: PEN_COUNT+1 entry palette, 1 write + 1 sync read     |
// | with write bypass; readback port under PALETTE_READBACK_EN. Rev 1.0     |
// +-------------------------------------------------------------------------+
module colour_palette_rf #(
  parameter int PEN_COUNT = 16,
  parameter int COLOUR_W  = 5,
  parameter int PAL_AW    = 5
) (
  input  logic                CLK_n,
  input  logic                RESET_n,
  input  logic                i_we,
  input  logic [PAL_AW-1:0]   i_waddr,
  input  logic [COLOUR_W-1:0] i_wdata,
  input  logic [PAL_AW-1:0]   i_raddr,
`ifdef PALETTE_READBACK_EN
  input  logic                i_re,
  output logic [COLOUR_W-1:0] o_rb_data,
`endif
  output logic [COLOUR_W-1:0] o_rdata
);

  localparam int                ENTRIES = PEN_COUNT + 1;
  localparam logic [PAL_AW-1:0] C_LAST  = PAL_AW'(PEN_COUNT);

  logic [COLOUR_W-1:0] r_pal [ENTRIES];
  logic                w_wr_ok;
  logic                w_rd_hit;
  logic [COLOUR_W-1:0] w_rd_val;

  assign w_wr_ok  = i_we && (i_waddr <= C_LAST);
  assign w_rd_hit = w_wr_ok && (i_waddr == i_raddr);
  assign w_rd_val = (i_raddr <= C_LAST) ? r_pal[i_raddr] : '0;

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < ENTRIES; i++) r_pal[i] <= '0;
    end else if (w_wr_ok) begin
      r_pal[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) o_rdata <= '0;
    else          o_rdata <= w_rd_hit ? i_wdata : w_rd_val;
  end

`ifdef PALETTE_READBACK_EN
  logic w_rb_hit;
  logic [COLOUR_W-1:0] w_rb_val;

  assign w_rb_hit = w_wr_ok && (i_waddr == i_raddr);
  assign w_rb_val = (i_raddr <= C_LAST) ? r_pal[i_raddr] : '0;

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n)  o_rb_data <= '0;
    else if (i_re) o_rb_data <= w_rb_hit ? i_wdata : w_rb_val;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/colour_pixel_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | colour_pixel_pipe: byte shifter -> pen decode -> palette -> colour reg  |
// | Optional PALETTE_READBACK_EN adds PAL_RE/PAL_RDATA. Rev 1.0             |
// +-------------------------------------------------------------------------+
import colour_pkg::*;

module colour_pixel_pipe #(
  parameter int PEN_COUNT = 16,
  parameter int COLOUR_W  = 5,
  parameter int PAL_AW    = 5
) (
  input  logic                CLK_n,
  input  logic                RESET_n,
  input  logic                PIX_CE,
  input  logic                LOAD,
  input  logic [7:0]          VDATA,
  input  logic [1:0]          MODE,
  input  logic                DISPEN,
  input  logic                BORDER_EN,
  input  logic                CKEEP,
  input  logic                PAL_WE,
  input  logic [PAL_AW-1:0]   PAL_ADDR,
  input  logic [COLOUR_W-1:0] PAL_WDATA,
`ifdef PALETTE_READBACK_EN
  input  logic                PAL_RE,
  output logic [COLOUR_W-1:0] PAL_RDATA,
`endif
  output logic [COLOUR_W-1:0] COLOUR,
  output logic [3:0]          PEN_OUT
);

  localparam int                PEN_BITS      = (PEN_COUNT > 1) ? $clog2(PEN_COUNT) : 1;
  localparam logic [PEN_W-1:0]  C_PEN_MASK    = PEN_W'((1 << PEN_BITS) - 1);
  localparam logic [PAL_AW-1:0] C_BORDER_ADDR = PAL_AW'(PEN_COUNT);

  logic [7:0]          r_shreg;
  mode_t               r_mode;
  logic [2:0]          r_tick;
  logic [2:0]          w_tick_inc;
  logic [2:0]          w_pix_mask;
  logic                w_boundary;
  logic [PEN_W-1:0]    w_pen;
  logic [PAL_AW-1:0]   w_rd_addr;
  logic [COLOUR_W-1:0] w_pal_rdata;

  logic                r_dispen_s2;
  logic                r_border_s2;
  logic                r_ckeep_s2;
  logic [PEN_W-1:0]    r_pen_s2;

  assign w_tick_inc = r_tick + 3'd1;
  assign w_pix_mask = pix_shift_ticks(r_mode) - 3'd1;
  assign w_boundary = (w_tick_inc & w_pix_mask) == 3'd0;

  // Tick 7 is the last pixel slot of a byte; a further tick without LOAD is an underrun.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      r_shreg <= '0;
      r_mode  <= MODE0;
      r_tick  <= '0;
    end else if (PIX_CE) begin
      if (LOAD) begin
        r_shreg <= VDATA;
        r_mode  <= mode_t'(MODE);
        r_tick  <= '0;
      end else if (r_tick == 3'd7) begin
        r_shreg <= '0;
      end else begin
        r_tick <= w_tick_inc;
        if (w_boundary) r_shreg <= {r_shreg[6:0], 1'b0};
      end
    end
  end

  assign w_pen     = pen_decode(r_mode, r_shreg) & C_PEN_MASK;
  assign w_rd_addr = BORDER_EN ? C_BORDER_ADDR : PAL_AW'(w_pen);

  colour_palette_rf #(
    .PEN_COUNT (PEN_COUNT),
    .COLOUR_W  (COLOUR_W),
    .PAL_AW    (PAL_AW)
  ) u_palette (
    .CLK_n     (CLK_n),
    .RESET_n   (RESET_n),
    .i_we      (PAL_WE),
    .i_waddr   (PAL_ADDR),
    .i_wdata   (PAL_WDATA),
    .i_raddr   (w_rd_addr),
`ifdef PALETTE_READBACK_EN
    .i_re      (PAL_RE),
    .o_rb_data (PAL_RDATA),
`endif
    .o_rdata   (w_pal_rdata)
  );

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      r_dispen_s2 <= 1'b0;
      r_border_s2 <= 1'b0;
      r_ckeep_s2  <= 1'b0;
      r_pen_s2    <= '0;
    end else begin
      r_dispen_s2 <= DISPEN;
      r_border_s2 <= BORDER_EN;
      r_ckeep_s2  <= CKEEP;
      r_pen_s2    <= w_pen;
    end
  end

  // The palette read already selected the border entry, so border and display share it.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      COLOUR  <= '0;
      PEN_OUT <= '0;
    end else begin
      PEN_OUT <= r_pen_s2;
      if (!r_ckeep_s2) COLOUR <= (r_border_s2 || r_dispen_s2) ? w_pal_rdata : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_colour_pixel_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_colour_pixel_pipe: directed and random checks against a pixel model  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_colour_pixel_pipe;

  logic       CLK_n = 1'b0;
  logic       RESET_n;
  logic       PIX_CE, LOAD, DISPEN, BORDER_EN, CKEEP, PAL_WE;
  logic [7:0] VDATA;
  logic [1:0] MODE;
  logic [4:0] PAL_ADDR, PAL_WDATA;
  logic [4:0] COLOUR;
  logic [3:0] PEN_OUT;
`ifdef PALETTE_READBACK_EN
  logic       PAL_RE = 1'b0;
  logic [4:0] PAL_RDATA;
`endif

  colour_pixel_pipe dut (
    .CLK_n     (CLK_n),
    .RESET_n   (RESET_n),
    .PIX_CE    (PIX_CE),
    .LOAD      (LOAD),
    .VDATA     (VDATA),
    .MODE      (MODE),
    .DISPEN    (DISPEN),
    .BORDER_EN (BORDER_EN),
    .CKEEP     (CKEEP),
    .PAL_WE    (PAL_WE),
    .PAL_ADDR  (PAL_ADDR),
    .PAL_WDATA (PAL_WDATA),
`ifdef PALETTE_READBACK_EN
    .PAL_RE    (PAL_RE),
    .PAL_RDATA (PAL_RDATA),
`endif
    .COLOUR    (COLOUR),
    .PEN_OUT   (PEN_OUT)
  );

  always #5 CLK_n = ~CLK_n;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: current byte, its mode and ticks elapsed since LOAD (8 = underrun).
  logic [4:0] m_pal [17];
  logic [7:0] m_byte;
  int         m_mode, m_ticks;
  logic [4:0] s2_val, exp_colour;
  logic       s2_ckeep;
  logic [3:0] s2_pen, exp_pen;

  function automatic logic [3:0] ref_pen(input logic [7:0] b, input int mode, input int ticks);
    int p;
    if (ticks >= 8) return 4'd0;
    case (mode)
      0: begin p = ticks / 4; return {b[1-p], b[5-p], b[3-p], b[7-p]}; end
      2: begin p = ticks;     return {3'b000, b[7-p]}; end
      default: begin p = ticks / 2; return {2'b00, b[3-p], b[7-p]}; end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 17; i++) m_pal[i] = '0;
    m_byte = '0; m_mode = 0; m_ticks = 0;
    s2_val = '0; s2_ckeep = 1'b0; s2_pen = '0;
    exp_colour = '0; exp_pen = '0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs now applied, clock once, compare both outputs.
  task automatic step();
    logic [3:0] pen;
    logic [4:0] nxt_colour;
    logic [3:0] nxt_pen;
    pen        = ref_pen(m_byte, m_mode, m_ticks);
    nxt_colour = s2_ckeep ? exp_colour : s2_val;
    nxt_pen    = s2_pen;
    if (PAL_WE && PAL_ADDR <= 5'd16) m_pal[PAL_ADDR] = PAL_WDATA;
    s2_val     = BORDER_EN ? m_pal[16] : (DISPEN ? m_pal[pen] : 5'd0);
    s2_ckeep   = CKEEP;
    s2_pen     = pen;
    exp_colour = nxt_colour;
    exp_pen    = nxt_pen;
    if (PIX_CE) begin
      if (LOAD) begin
        m_byte = VDATA; m_mode = int'(MODE); m_ticks = 0;
      end else if (m_ticks < 8) begin
        m_ticks++;
      end
    end
    @(posedge CLK_n); #1;
    check("model_colour", {3'b0, COLOUR}, {3'b0, exp_colour});
    check("model_pen", {4'b0, PEN_OUT}, {4'b0, exp_pen});
  endtask

  task automatic wr_pal(input logic [4:0] addr, input logic [4:0] data);
    PAL_WE = 1'b1; PAL_ADDR = addr; PAL_WDATA = data;
    step();
    PAL_WE = 1'b0;
  endtask

  logic [4:0] m2_exp [8];
  logic [3:0] tr_exp [7];

  initial begin
    m2_exp = '{5'h0B, 5'h04, 5'h0B, 5'h04, 5'h04, 5'h0B, 5'h04, 5'h0B};
    tr_exp = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
    PIX_CE = 1'b1; LOAD = 1'b0; VDATA = '0; MODE = '0; DISPEN = 1'b0;
    BORDER_EN = 1'b0; CKEEP = 1'b0; PAL_WE = 1'b0; PAL_ADDR = '0; PAL_WDATA = '0;
    model_reset();
    RESET_n = 1'b0;
    #12;
    check("reset_colour", {3'b0, COLOUR}, 8'h00);
    check("reset_pen", {4'b0, PEN_OUT}, 8'h00);
    RESET_n = 1'b1;

    // Mode 2 byte A5
    wr_pal(5'd0, 5'h04);
    wr_pal(5'd1, 5'h0B);
    DISPEN = 1'b1; MODE = 2'd2; VDATA = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      LOAD = (i == 0);
      step();
      if (i >= 2) check("mode2_seq", {3'b0, COLOUR}, {3'b0, m2_exp[i-2]});
    end

    // Mode 0 byte 80: pen 1 for four ticks, then pen 0
    wr_pal(5'd1, 5'h12);
    MODE = 2'd0; VDATA = 8'h80;
    for (int i = 0; i < 10; i++) begin
      LOAD = (i == 0);
      step();
      if (i >= 2) check("mode0_seq", {3'b0, COLOUR}, (i < 6) ? 8'h12 : 8'h04);
    end

    // Border beats everything, then colour-keep freezes the output
    wr_pal(5'd16, 5'h14);
    BORDER_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      LOAD = (i == 0); VDATA = 8'($urandom); MODE = 2'($urandom_range(0, 2));
      step();
      if (i >= 2) check("border", {3'b0, COLOUR}, 8'h14);
    end
    BORDER_EN = 1'b0; CKEEP = 1'b1; MODE = 2'd2; VDATA = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      LOAD = (i == 0);
      step();
      check("ckeep_hold", {3'b0, COLOUR}, 8'h14);
    end
    CKEEP = 1'b0; LOAD = 1'b0;
    step(); step();

    // Underrun: 8 pixels of pen 1 then pen 0
    MODE = 2'd2; VDATA = 8'hFF;
    for (int i = 0; i < 13; i++) begin
      LOAD = (i == 0);
      step();
      if (i >= 2) check("underrun_pen", {4'b0, PEN_OUT}, (i < 10) ? 8'd1 : 8'd0);
    end

    // Reload at tick 3 truncates the previous byte
    for (int i = 0; i < 9; i++) begin
      LOAD = (i == 0 || i == 3); VDATA = (i == 0) ? 8'hF0 : 8'h55;
      step();
      if (i >= 2) check("reload_pen", {4'b0, PEN_OUT}, {4'b0, tr_exp[i-2]});
    end

    // Write/read collision on pen 1 returns the new value
    VDATA = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      LOAD = (i == 0);
      PAL_WE = (i == 1); PAL_ADDR = 5'd1; PAL_WDATA = 5'h1F;
      step();
      if (i == 2) check("bypass", {3'b0, COLOUR}, 8'h1F);
    end
    PAL_WE = 1'b0;

    // Out-of-range write must not alias onto pen 4
    wr_pal(5'd4, 5'h09);
    wr_pal(5'd20, 5'h1E);
    MODE = 2'd0; VDATA = 8'h20;
    for (int i = 0; i < 4; i++) begin
      LOAD = (i == 0);
      step();
      if (i >= 2) check("addr20_drop", {3'b0, COLOUR}, 8'h09);
    end

    // Asynchronous reset in the middle of a byte
    MODE = 2'd2; VDATA = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      LOAD = (i == 0);
      step();
    end
    LOAD = 1'b0;
    #3 RESET_n = 1'b0;
    #1;
    check("async_colour", {3'b0, COLOUR}, 8'h00);
    check("async_pen", {4'b0, PEN_OUT}, 8'h00);
    model_reset();
    @(posedge CLK_n); #1;
    RESET_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      LOAD = (i == 0);
      step();
      if (i >= 2) check("pal_cleared", {3'b0, COLOUR}, 8'h00);
    end
    BORDER_EN = 1'b1;
    step(); step();
    check("border_cleared", {3'b0, COLOUR}, 8'h00);
    BORDER_EN = 1'b0;

    // Random traffic against the model
    for (int a = 0; a < 17; a++) wr_pal(5'(a), 5'($urandom));
    for (int i = 0; i < 400; i++) begin
      PIX_CE    = ($urandom_range(0, 3) != 0);
      LOAD      = ($urandom_range(0, 5) == 0);
      VDATA     = 8'($urandom);
      MODE      = 2'($urandom_range(0, 2));
      DISPEN    = ($urandom_range(0, 7) != 0);
      BORDER_EN = ($urandom_range(0, 9) == 0);
      CKEEP     = ($urandom_range(0, 11) == 0);
      PAL_WE    = ($urandom_range(0, 15) == 0);
      PAL_ADDR  = 5'($urandom_range(0, 23));
      PAL_WDATA = 5'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
